bp_fe_ras_ctrl: RTL and testbench
=================================

Name: bp_fe_ras_ctrl

Overview:
Sequencing and recovery controller for the front-end return-address stack (RAS); 31 usable entries, 64-bit data.
- Takes call/return events from predecode and issues single-cycle push/pop strobes to the RAS.
- Serializes same-cycle call+return (tail-call swap).
- Keeps a per-branch-tag checkpoint table and a LIFO history of popped addresses.
- On a backend redirect, replays pops/pushes to restore the RAS to its checkpointed state, one operation per cycle, while holding off the front end.

Parameters:
ras_idx_width_p, 5, RAS index width; max depth = 2**ras_idx_width_p - 1
eaddr_width_p, 64, return-address width
tag_width_p, 3, branch-tag width; checkpoint table has 2**tag_width_p entries
hist_els_p, 4, popped-address history depth
hist_cnt_width_p, 8, width of the running pop counter stored in checkpoints

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
call_v_i  in  1  call detected
call_addr_i  in  eaddr_width_p  return address to push
ret_v_i  in  1  return detected
ready_o  out  1  call/ret/ckpt accepted this cycle
ckpt_v_i  in  1  record checkpoint
ckpt_tag_i  in  tag_width_p  checkpoint slot
redirect_v_i  in  1  restore to checkpoint
redirect_tag_i  in  tag_width_p  checkpoint to restore
ras_top_i  in  eaddr_width_p  current RAS top-of-stack data
ras_push_o  out  1  push strobe to RAS
ras_pop_o  out  1  pop strobe to RAS
ras_data_o  out  eaddr_width_p  push data
depth_o  out  ras_idx_width_p  tracked RAS occupancy
busy_o  out  1  restore in progress
drop_o  out  1  pulse: push at full or pop at empty suppressed
ras_lost_o  out  1  sticky: restore incomplete

Behaviour:
- Clocking and reset (already decided): one clock, clk_i; reset_n_i is asynchronous and active-low.
- Reset values:
  - State = IDLE; depth = 0; pop counter = 0; history empty; checkpoint table all 0.
  - All outputs 0, except ready_o = 1.
  - Reset mid-restore aborts the restore immediately.
- At most one of ras_push_o / ras_pop_o is high per cycle. Both are registered: a strobe appears the cycle after the event is accepted.
- IDLE, call only:
  - If depth < max: push call_addr_i; depth += 1.
  - Else: drop_o = 1; counters unchanged.
- IDLE, ret only:
  - If depth > 0: pop; capture ras_top_i into the history (oldest entry overwritten when full); pop counter += 1; depth -= 1.
  - Else: drop_o = 1.
- IDLE, call and ret in the same cycle:
  - Pop this cycle and go to SWAP; ready_o = 0.
  - SWAP pushes the latched call_addr_i, then returns to IDLE. Net depth is unchanged.
- ckpt_v_i:
  - Writes {depth, pop counter}, sampled before this cycle's call/ret, to table[ckpt_tag_i].
  - Honoured whenever ready_o = 1.
- redirect_v_i has top priority. Any call/ret/ckpt in the same cycle is discarded.
- Redirect computation, with (Dt, Ht) = table[redirect_tag_i]:
  - P = (pop counter - Ht) mod 2**hist_cnt_width_p.
  - Q = depth - Dt + P.
  - Go to R_POP; busy_o = 1; ready_o = 0.
- R_POP: one pop per cycle, Q times. These pops are not recorded in the history.
- R_PUSH: P ≤ hist_els_p and hist_count ≥ P. Push history entries newest-first, P times, removing each from the history.
- When P > hist_els_p or P > hist_count:
  - Skip R_PUSH and set ras_lost_o.
  - depth_o ends at Dt - P.
- On completion: pop counter = Ht; go to IDLE.
- Q = 0 and P = 0: return to IDLE in the next cycle.
- A redirect during R_POP/R_PUSH/SWAP recomputes P and Q from the current counters; the new restore starts the next cycle.
- The pop counter wraps mod 2**hist_cnt_width_p. More than 2**hist_cnt_width_p - 1 pops between checkpoint and redirect is unsupported.

Optional Feature:
BP_FE_RAS_CTRL_STATS_EN:
- Defined: adds outputs stat_drop_o, stat_restore_o, stat_lost_o (32-bit saturating counters).
  - Counters increment on drop_o, on redirect acceptance and on ras_lost_o set, respectively.
  - Cleared by reset.
- Undefined: the ports and counters are absent; no other change.

Decomposition:
- bp_fe_pkg holds:
  - bp_fe_ras_ctrl_state_e (IDLE, SWAP, R_POP, R_PUSH);
  - bp_fe_ras_ckpt_s {depth, pop_cnt};
  - localparam for max depth.
- One sub-module, bp_fe_ras_ctrl_hist: circular LIFO of hist_els_p entries with push (overwrite-oldest), pop, top and count.

Test Plan:
- Reset, then 3 calls 0x100/0x200/0x300 -> 3 push strobes with those data; depth_o = 3; then 1 ret -> pop; history top = 0x300; depth_o = 2.
- 31 calls then a 32nd call -> 32nd suppressed, drop_o pulses once, depth_o = 31; ret at depth 0 -> drop_o, no pop.
- Same-cycle call 0xA0 + ret at depth 2 -> pop in cycle 1, push 0xA0 in cycle 2, ready_o low for 1 cycle, depth_o = 2.
- ckpt tag 5 at depth 4; then ret, ret, call 0xC0; redirect tag 5 -> P = 2, Q = 1; sequence: pop, push(2nd popped), push(1st popped); depth_o = 4; busy_o high for 3 cycles.
- ckpt, then 6 rets (hist_els_p = 4), redirect -> 0 pops, no pushes, ras_lost_o = 1, depth_o = Dt - 6.
- Redirect asserted during R_POP, and reset_n_i asserted mid-restore -> restore retargets next cycle; on reset, outputs return to reset values immediately.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared types and constants for the front-end RAS controller.
package bp_fe_pkg;

    localparam int RAS_IDX_WIDTH  = 5;
    localparam int HIST_CNT_WIDTH = 8;
    localparam int RAS_MAX_DEPTH  = 2**RAS_IDX_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        SWAP,
        R_POP,
        R_PUSH
    } bp_fe_ras_ctrl_state_e;

    typedef struct packed {
        logic [RAS_IDX_WIDTH-1:0]  depth;
        logic [HIST_CNT_WIDTH-1:0] pop_cnt;
    } bp_fe_ras_ckpt_s;

endpackage

// File: rtl/bp_fe_ras_ctrl_hist.sv
// Circular LIFO of recently popped return addresses; a push when full overwrites the oldest entry.
module bp_fe_ras_ctrl_hist #(
    parameter int els_p       = 4,
    parameter int width_p     = 64,
    parameter int cnt_width_p = $clog2(els_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   push_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   pop_i,
    output logic [width_p-1:0]     top_o,
    output logic [cnt_width_p-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_p-1:0]  full_cnt_lp = cnt_width_p'(els_p);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wr_ptr_q;
    logic [ptr_width_lp-1:0] rd_ptr;
    logic [cnt_width_p-1:0]  cnt_q;

    assign rd_ptr  = (wr_ptr_q == '0) ? last_ptr_lp : wr_ptr_q - ptr_width_lp'(1);
    assign top_o   = mem_q[rd_ptr];
    assign count_o = cnt_q;

    // NOTE: storage has no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push_i) begin
            wr_ptr_q <= (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
            if (cnt_q != full_cnt_lp) begin
                cnt_q <= cnt_q + cnt_width_p'(1);
            end
        end else if (pop_i && cnt_q != '0) begin
            wr_ptr_q <= rd_ptr;
            cnt_q    <= cnt_q - cnt_width_p'(1);
        end
    end

endmodule

// File: rtl/bp_fe_ras_ctrl.sv
// RAS push/pop sequencer with checkpoint-based redirect recovery.
// Optional statistics counters are enabled with `define BP_FE_RAS_CTRL_STATS_EN.
module bp_fe_ras_ctrl
    import bp_fe_pkg::*;
#(
    parameter int ras_idx_width_p  = RAS_IDX_WIDTH,
    parameter int eaddr_width_p    = 64,
    parameter int tag_width_p      = 3,
    parameter int hist_els_p       = 4,
    parameter int hist_cnt_width_p = HIST_CNT_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       call_v_i,
    input  logic [eaddr_width_p-1:0]   call_addr_i,
    input  logic                       ret_v_i,
    output logic                       ready_o,
    input  logic                       ckpt_v_i,
    input  logic [tag_width_p-1:0]     ckpt_tag_i,
    input  logic                       redirect_v_i,
    input  logic [tag_width_p-1:0]     redirect_tag_i,
    input  logic [eaddr_width_p-1:0]   ras_top_i,
    output logic                       ras_push_o,
    output logic                       ras_pop_o,
    output logic [eaddr_width_p-1:0]   ras_data_o,
    output logic [ras_idx_width_p-1:0] depth_o,
    output logic                       busy_o,
    output logic                       drop_o,
    output logic                       ras_lost_o
`ifdef BP_FE_RAS_CTRL_STATS_EN
    ,
    output logic [31:0]                stat_drop_o,
    output logic [31:0]                stat_restore_o,
    output logic [31:0]                stat_lost_o
`endif
);

    localparam int hcw_lp = $clog2(hist_els_p + 1);
    localparam int qw_lp  = ((ras_idx_width_p > hist_cnt_width_p) ? ras_idx_width_p : hist_cnt_width_p) + 1;
    localparam int sw_lp  = qw_lp + 1;
    localparam logic [ras_idx_width_p-1:0] max_depth_lp = ras_idx_width_p'(RAS_MAX_DEPTH);

    // The checkpoint struct is sized by the package, so the widths must agree.
    if (ras_idx_width_p != RAS_IDX_WIDTH || hist_cnt_width_p != HIST_CNT_WIDTH) begin : g_bad_cfg
        $error("bp_fe_ras_ctrl: index/counter widths must match bp_fe_pkg");
    end

    bp_fe_ras_ctrl_state_e         state_q;
    logic [ras_idx_width_p-1:0]    depth_q, depth_inc, depth_dec;
    logic [hist_cnt_width_p-1:0]   pop_cnt_q, p_cnt_q, ht_q, p_calc;
    logic [qw_lp-1:0]              q_cnt_q, q_calc;
    logic signed [sw_lp-1:0]       q_signed;
    logic                          push_q, pop_q, drop_q, lost_q, push_ok_q, push_ok_calc;
    logic [eaddr_width_p-1:0]      data_q, hist_top;
    logic [hcw_lp-1:0]             hist_cnt;
    logic                          hist_push, hist_pop;
    bp_fe_ras_ckpt_s               ckpt_tbl_q [2**tag_width_p];
    bp_fe_ras_ckpt_s               ckpt_rd;

    assign depth_inc = depth_q + ras_idx_width_p'(1);
    assign depth_dec = depth_q - ras_idx_width_p'(1);

    // Restore plan: P history pushes undo the pops since the checkpoint, Q pops undo everything else.
    assign ckpt_rd      = ckpt_tbl_q[redirect_tag_i];
    assign p_calc       = pop_cnt_q - ckpt_rd.pop_cnt;
    assign q_signed     = $signed(sw_lp'(depth_q)) - $signed(sw_lp'(ckpt_rd.depth)) + $signed(sw_lp'(p_calc));
    assign q_calc       = q_signed[sw_lp-1] ? '0 : q_signed[qw_lp-1:0];
    assign push_ok_calc = (p_calc <= hist_cnt_width_p'(hist_els_p)) && (hist_cnt_width_p'(hist_cnt) >= p_calc);

    assign ready_o    = (state_q == IDLE);
    assign busy_o     = (state_q == R_POP) || (state_q == R_PUSH);
    assign ras_push_o = push_q;
    assign ras_pop_o  = pop_q;
    assign ras_data_o = data_q;
    assign depth_o    = depth_q;
    assign drop_o     = drop_q;
    assign ras_lost_o = lost_q;

    always_comb begin
        hist_push = 1'b0;
        hist_pop  = 1'b0;
        if (!redirect_v_i) begin
            hist_push = (state_q == IDLE) && ret_v_i && (depth_q != '0);
            hist_pop  = (state_q == R_PUSH)
                     || ((state_q == R_POP) && (q_cnt_q == '0) && push_ok_q && (p_cnt_q != '0));
        end
    end

    bp_fe_ras_ctrl_hist #(
        .els_p       (hist_els_p),
        .width_p     (eaddr_width_p),
        .cnt_width_p (hcw_lp)
    ) u_hist (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (hist_push),
        .data_i    (ras_top_i),
        .pop_i     (hist_pop),
        .top_o     (hist_top),
        .count_o   (hist_cnt)
    );

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            depth_q   <= '0;
            pop_cnt_q <= '0;
            q_cnt_q   <= '0;
            p_cnt_q   <= '0;
            ht_q      <= '0;
            push_ok_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            drop_q    <= 1'b0;
            lost_q    <= 1'b0;
            data_q    <= '0;
            for (int i = 0; i < 2**tag_width_p; i++) begin
                ckpt_tbl_q[i] <= '0;
            end
        end else begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            drop_q <= 1'b0;
            if (redirect_v_i) begin
                state_q   <= R_POP;
                q_cnt_q   <= q_calc;
                p_cnt_q   <= p_calc;
                ht_q      <= ckpt_rd.pop_cnt;
                push_ok_q <= push_ok_calc;
                if (!push_ok_calc) begin
                    lost_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ckpt_v_i) begin
                            ckpt_tbl_q[ckpt_tag_i] <= '{depth: depth_q, pop_cnt: pop_cnt_q};
                        end
                        if (call_v_i && ret_v_i && depth_q != '0) begin
                            pop_q     <= 1'b1;
                            data_q    <= call_addr_i;
                            depth_q   <= depth_dec;
                            pop_cnt_q <= pop_cnt_q + hist_cnt_width_p'(1);
                            state_q   <= SWAP;
                        end else if (call_v_i) begin
                            // A return paired with a call at empty depth is dropped here.
                            drop_q <= ret_v_i || (depth_q == max_depth_lp);
                            if (depth_q != max_depth_lp) begin
                                push_q  <= 1'b1;
                                data_q  <= call_addr_i;
                                depth_q <= depth_inc;
                            end
                        end else if (ret_v_i) begin
                            if (depth_q != '0) begin
                                pop_q     <= 1'b1;
                                depth_q   <= depth_dec;
                                pop_cnt_q <= pop_cnt_q + hist_cnt_width_p'(1);
                            end else begin
                                drop_q <= 1'b1;
                            end
                        end
                    end
                    SWAP: begin
                        push_q  <= 1'b1;
                        depth_q <= depth_inc;
                        state_q <= IDLE;
                    end
                    R_POP: begin
                        if (q_cnt_q != '0) begin
                            if (depth_q != '0) begin
                                pop_q   <= 1'b1;
                                depth_q <= depth_dec;
                            end
                            q_cnt_q <= q_cnt_q - qw_lp'(1);
                            if (q_cnt_q == qw_lp'(1)) begin
                                if (push_ok_q && p_cnt_q != '0) begin
                                    state_q <= R_PUSH;
                                end else begin
                                    state_q   <= IDLE;
                                    pop_cnt_q <= ht_q;
                                end
                            end
                        end else if (push_ok_q && p_cnt_q != '0) begin
                            push_q  <= 1'b1;
                            data_q  <= hist_top;
                            depth_q <= depth_inc;
                            p_cnt_q <= p_cnt_q - hist_cnt_width_p'(1);
                            if (p_cnt_q == hist_cnt_width_p'(1)) begin
                                state_q   <= IDLE;
                                pop_cnt_q <= ht_q;
                            end else begin
                                state_q <= R_PUSH;
                            end
                        end else begin
                            state_q   <= IDLE;
                            pop_cnt_q <= ht_q;
                        end
                    end
                    R_PUSH: begin
                        push_q  <= 1'b1;
                        data_q  <= hist_top;
                        depth_q <= depth_inc;
                        p_cnt_q <= p_cnt_q - hist_cnt_width_p'(1);
                        if (p_cnt_q == hist_cnt_width_p'(1)) begin
                            state_q   <= IDLE;
                            pop_cnt_q <= ht_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef BP_FE_RAS_CTRL_STATS_EN
    logic [31:0] stat_drop_q, stat_restore_q, stat_lost_q;

    assign stat_drop_o    = stat_drop_q;
    assign stat_restore_o = stat_restore_q;
    assign stat_lost_o    = stat_lost_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_drop_q    <= '0;
            stat_restore_q <= '0;
            stat_lost_q    <= '0;
        end else begin
            if (drop_q && stat_drop_q != '1) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
            if (redirect_v_i && stat_restore_q != '1) begin
                stat_restore_q <= stat_restore_q + 32'd1;
            end
            if (redirect_v_i && !push_ok_calc && !lost_q && stat_lost_q != '1) begin
                stat_lost_q <= stat_lost_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Directed self-checking bench for bp_fe_ras_ctrl (default build).
module tb_bp_fe_ras_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        call_v_i;
    logic [63:0] call_addr_i;
    logic        ret_v_i;
    logic        ready_o;
    logic        ckpt_v_i;
    logic [2:0]  ckpt_tag_i;
    logic        redirect_v_i;
    logic [2:0]  redirect_tag_i;
    logic [63:0] ras_top_i;
    logic        ras_push_o;
    logic        ras_pop_o;
    logic [63:0] ras_data_o;
    logic [4:0]  depth_o;
    logic        busy_o;
    logic        drop_o;
    logic        ras_lost_o;
`ifdef BP_FE_RAS_CTRL_STATS_EN
    logic [31:0] stat_drop_o, stat_restore_o, stat_lost_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_ras_ctrl dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .call_v_i       (call_v_i),
        .call_addr_i    (call_addr_i),
        .ret_v_i        (ret_v_i),
        .ready_o        (ready_o),
        .ckpt_v_i       (ckpt_v_i),
        .ckpt_tag_i     (ckpt_tag_i),
        .redirect_v_i   (redirect_v_i),
        .redirect_tag_i (redirect_tag_i),
        .ras_top_i      (ras_top_i),
        .ras_push_o     (ras_push_o),
        .ras_pop_o      (ras_pop_o),
        .ras_data_o     (ras_data_o),
        .depth_o        (depth_o),
        .busy_o         (busy_o),
        .drop_o         (drop_o),
        .ras_lost_o     (ras_lost_o)
`ifdef BP_FE_RAS_CTRL_STATS_EN
        ,
        .stat_drop_o    (stat_drop_o),
        .stat_restore_o (stat_restore_o),
        .stat_lost_o    (stat_lost_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        call_v_i       = 1'b0;
        call_addr_i    = '0;
        ret_v_i        = 1'b0;
        ckpt_v_i       = 1'b0;
        ckpt_tag_i     = '0;
        redirect_v_i   = 1'b0;
        redirect_tag_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        ras_top_i = '0;
        reset_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic do_call(input logic [63:0] addr);
        clear_inputs();
        call_v_i    = 1'b1;
        call_addr_i = addr;
        tick();
        clear_inputs();
    endtask

    task automatic do_ret(input logic [63:0] top);
        clear_inputs();
        ret_v_i   = 1'b1;
        ras_top_i = top;
        tick();
        clear_inputs();
    endtask

    task automatic do_ckpt(input logic [2:0] tag);
        clear_inputs();
        ckpt_v_i   = 1'b1;
        ckpt_tag_i = tag;
        tick();
        clear_inputs();
    endtask

    task automatic do_redirect(input logic [2:0] tag);
        clear_inputs();
        redirect_v_i   = 1'b1;
        redirect_tag_i = tag;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({ready_o, ras_push_o, ras_pop_o, busy_o, drop_o, ras_lost_o} !== 6'b100000) begin
            $display("FAIL reset_flags: got %b expected 100000",
                     {ready_o, ras_push_o, ras_pop_o, busy_o, drop_o, ras_lost_o});
            tests_failed++;
        end
        tests_run++;
        if (depth_o !== 5'd0 || ras_data_o !== 64'd0) begin
            $display("FAIL reset_values: depth %0d data %0h expected 0 0", depth_o, ras_data_o);
            tests_failed++;
        end
    endtask

    task automatic test_calls_ret();
        logic [63:0] addrs [3];
        addrs[0] = 64'h100;
        addrs[1] = 64'h200;
        addrs[2] = 64'h300;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_call(addrs[i]);
            tests_run++;
            if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b0 || ras_data_o !== addrs[i]
                || depth_o !== 5'(i + 1)) begin
                $display("FAIL call_%0d: push %b pop %b data %0h depth %0d expected 1 0 %0h %0d",
                         i, ras_push_o, ras_pop_o, ras_data_o, depth_o, addrs[i], i + 1);
                tests_failed++;
            end
        end
        // Checkpoint and return in the same cycle: checkpoint sees depth 3.
        clear_inputs();
        ckpt_v_i   = 1'b1;
        ckpt_tag_i = 3'd1;
        ret_v_i    = 1'b1;
        ras_top_i  = 64'h300;
        tick();
        clear_inputs();
        tests_run++;
        if (ras_pop_o !== 1'b1 || ras_push_o !== 1'b0 || depth_o !== 5'd2) begin
            $display("FAIL ret_pop: pop %b push %b depth %0d expected 1 0 2", ras_pop_o, ras_push_o, depth_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_pop_o !== 1'b0) begin
            $display("FAIL ret_single_strobe: pop %b expected 0", ras_pop_o);
            tests_failed++;
        end
        // P = 1, Q = 0: one history push brings back 0x300.
        do_redirect(3'd1);
        tests_run++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0 || ras_push_o !== 1'b0) begin
            $display("FAIL hist_restore_busy: busy %b ready %b push %b expected 1 0 0", busy_o, ready_o, ras_push_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_push_o !== 1'b1 || ras_data_o !== 64'h300 || depth_o !== 5'd3 || busy_o !== 1'b0) begin
            $display("FAIL hist_top: push %b data %0h depth %0d busy %b expected 1 300 3 0",
                     ras_push_o, ras_data_o, depth_o, busy_o);
            tests_failed++;
        end
    endtask

    task automatic test_full_empty();
        apply_reset();
        for (int i = 1; i <= 31; i++) begin
            do_call(64'(i));
        end
        tests_run++;
        if (ras_push_o !== 1'b1 || depth_o !== 5'd31 || drop_o !== 1'b0) begin
            $display("FAIL fill_31: push %b depth %0d drop %b expected 1 31 0", ras_push_o, depth_o, drop_o);
            tests_failed++;
        end
        do_call(64'h999);
        tests_run++;
        if (ras_push_o !== 1'b0 || drop_o !== 1'b1 || depth_o !== 5'd31) begin
            $display("FAIL overflow_drop: push %b drop %b depth %0d expected 0 1 31", ras_push_o, drop_o, depth_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (drop_o !== 1'b0) begin
            $display("FAIL drop_pulse: drop %b expected 0", drop_o);
            tests_failed++;
        end
        apply_reset();
        do_ret(64'h55);
        tests_run++;
        if (ras_pop_o !== 1'b0 || drop_o !== 1'b1 || depth_o !== 5'd0) begin
            $display("FAIL underflow_drop: pop %b drop %b depth %0d expected 0 1 0", ras_pop_o, drop_o, depth_o);
            tests_failed++;
        end
    endtask

    task automatic test_swap();
        apply_reset();
        do_call(64'h10);
        do_call(64'h20);
        clear_inputs();
        call_v_i    = 1'b1;
        call_addr_i = 64'hA0;
        ret_v_i     = 1'b1;
        ras_top_i   = 64'h20;
        tick();
        clear_inputs();
        tests_run++;
        if (ras_pop_o !== 1'b1 || ras_push_o !== 1'b0 || ready_o !== 1'b0 || depth_o !== 5'd1) begin
            $display("FAIL swap_pop: pop %b push %b ready %b depth %0d expected 1 0 0 1",
                     ras_pop_o, ras_push_o, ready_o, depth_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b0 || ras_data_o !== 64'hA0
            || ready_o !== 1'b1 || depth_o !== 5'd2) begin
            $display("FAIL swap_push: push %b pop %b data %0h ready %b depth %0d expected 1 0 a0 1 2",
                     ras_push_o, ras_pop_o, ras_data_o, ready_o, depth_o);
            tests_failed++;
        end
    endtask

    task automatic test_restore();
        logic [63:0] exp_data [2];
        exp_data[0] = 64'h3;
        exp_data[1] = 64'h4;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            do_call(64'(i));
        end
        do_ckpt(3'd5);
        do_ret(64'h4);
        do_ret(64'h3);
        do_call(64'hC0);
        // Depth 3, two pops since checkpoint: P = 2, Q = 1.
        do_redirect(3'd5);
        tests_run++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0 || ras_pop_o !== 1'b0 || ras_push_o !== 1'b0) begin
            $display("FAIL restore_enter: busy %b ready %b pop %b push %b expected 1 0 0 0",
                     busy_o, ready_o, ras_pop_o, ras_push_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_pop_o !== 1'b1 || ras_push_o !== 1'b0 || depth_o !== 5'd2 || busy_o !== 1'b1) begin
            $display("FAIL restore_pop: pop %b push %b depth %0d busy %b expected 1 0 2 1",
                     ras_pop_o, ras_push_o, depth_o, busy_o);
            tests_failed++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b0 || ras_data_o !== exp_data[i]
                || depth_o !== 5'(3 + i) || busy_o !== (i == 0)) begin
                $display("FAIL restore_push_%0d: push %b data %0h depth %0d busy %b expected 1 %0h %0d %b",
                         i, ras_push_o, ras_data_o, depth_o, busy_o, exp_data[i], 3 + i, i == 0);
                tests_failed++;
            end
        end
        // Same checkpoint again: pop counter was restored, so nothing to do.
        do_redirect(3'd5);
        tick();
        tests_run++;
        if (ras_push_o !== 1'b0 || ras_pop_o !== 1'b0 || busy_o !== 1'b0
            || depth_o !== 5'd4 || ras_lost_o !== 1'b0) begin
            $display("FAIL restore_noop: push %b pop %b busy %b depth %0d lost %b expected 0 0 0 4 0",
                     ras_push_o, ras_pop_o, busy_o, depth_o, ras_lost_o);
            tests_failed++;
        end
    endtask

    task automatic test_lost();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            do_call(64'(i));
        end
        do_ckpt(3'd3);
        for (int i = 0; i < 6; i++) begin
            do_ret(64'(8 - i));
        end
        do_redirect(3'd3);
        tests_run++;
        if (ras_lost_o !== 1'b1 || busy_o !== 1'b1) begin
            $display("FAIL lost_set: lost %b busy %b expected 1 1", ras_lost_o, busy_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_push_o !== 1'b0 || ras_pop_o !== 1'b0 || busy_o !== 1'b0 || depth_o !== 5'd2) begin
            $display("FAIL lost_done: push %b pop %b busy %b depth %0d expected 0 0 0 2",
                     ras_push_o, ras_pop_o, busy_o, depth_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_lost_o !== 1'b1) begin
            $display("FAIL lost_sticky: lost %b expected 1", ras_lost_o);
            tests_failed++;
        end
    endtask

    task automatic test_retarget_reset();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            do_call(64'(i));
        end
        do_ckpt(3'd0);
        do_call(64'h5);
        do_ckpt(3'd1);
        do_call(64'h6);
        do_call(64'h7);
        // Tag 0 gives Q = 3; retarget to tag 1 after the first pop.
        do_redirect(3'd0);
        tick();
        tests_run++;
        if (ras_pop_o !== 1'b1 || depth_o !== 5'd6) begin
            $display("FAIL retarget_first_pop: pop %b depth %0d expected 1 6", ras_pop_o, depth_o);
            tests_failed++;
        end
        do_redirect(3'd1);
        tests_run++;
        if (ras_pop_o !== 1'b0 || busy_o !== 1'b1 || depth_o !== 5'd6) begin
            $display("FAIL retarget_restart: pop %b busy %b depth %0d expected 0 1 6", ras_pop_o, busy_o, depth_o);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ras_pop_o !== 1'b1 || busy_o !== 1'b0 || depth_o !== 5'd5) begin
            $display("FAIL retarget_done: pop %b busy %b depth %0d expected 1 0 5", ras_pop_o, busy_o, depth_o);
            tests_failed++;
        end
        do_redirect(3'd0);
        #2;
        reset_n_i = 1'b0;
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || ready_o !== 1'b1 || depth_o !== 5'd0 || ras_pop_o !== 1'b0) begin
            $display("FAIL reset_mid_restore: busy %b ready %b depth %0d pop %b expected 0 1 0 0",
                     busy_o, ready_o, depth_o, ras_pop_o);
            tests_failed++;
        end
        tick();
        reset_n_i = 1'b1;
        tick();
        tests_run++;
        if (ras_pop_o !== 1'b0 || busy_o !== 1'b0 || depth_o !== 5'd0) begin
            $display("FAIL after_reset_idle: pop %b busy %b depth %0d expected 0 0 0", ras_pop_o, busy_o, depth_o);
            tests_failed++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0;
        ras_top_i = '0;
        clear_inputs();
        test_reset();
        test_calls_ret();
        test_full_empty();
        test_swap();
        test_restore();
        test_lost();
        test_retarget_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
